// File: rtl/switch_input_ctrl.sv
// Memory-mapped switch/button input port: synchronises and debounces the pins,
// tracks confirm presses and switch changes, and returns address-selected read data.
module switch_input_ctrl #(
  parameter int SW_WIDTH        = 16,
  parameter int DATA_WIDTH      = 16,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  switchCtrl,
  input  logic [31:0]           address,
  input  logic [SW_WIDTH-1:0]   switchInput,
  input  logic                  confirmation,
  output logic [DATA_WIDTH-1:0] dataIOInput,
  output logic                  dataValid,
  output logic                  confirmPending
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]      DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  localparam logic [31:0] ADDR_CONFIRM = 32'hFFFF_FF00;
  localparam logic [31:0] ADDR_COUNT   = 32'hFFFF_FF02;
  localparam logic [31:0] ADDR_SW      = 32'hFFFF_FFF1;
  localparam logic [31:0] ADDR_UB_SEXT = 32'hFFFF_FFF3;
  localparam logic [31:0] ADDR_UB_ZEXT = 32'hFFFF_FFF5;
  localparam logic [31:0] ADDR_SW3     = 32'hFFFF_FFF7;
  localparam logic [31:0] ADDR_SW8     = 32'hFFFF_FFF9;
  localparam logic [31:0] ADDR_CHANGED = 32'hFFFF_FFFB;

  logic [SW_WIDTH-1:0]   sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [SW_WIDTH-1:0]   sw_cand_q, sw_cand_d, sw_db_q, sw_db_d;
  logic [DB_W-1:0]       sw_cnt_q, sw_cnt_d;
  logic                  btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic                  btn_cand_q, btn_cand_d, btn_db_q, btn_db_d;
  logic [DB_W-1:0]       btn_cnt_q, btn_cnt_d;
  logic                  pending_q, pending_d, changed_q, changed_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  logic                  btn_rise_s, sw_change_s;
  logic                  rd_confirm_s, rd_count_s, rd_changed_s;
  logic [7:0]            ub_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  // Two-flop synchronisers and per-channel debounce counters
  always_comb begin
    sw_s1_d  = switchInput;
    sw_s2_d  = sw_s1_q;
    btn_s1_d = confirmation;
    btn_s2_d = btn_s1_q;

    if (sw_s2_q != sw_cand_q) begin
      sw_cand_d = sw_s2_q;
      sw_cnt_d  = {DB_W{1'b0}};
      sw_db_d   = sw_db_q;
    end else if (sw_cnt_q == DB_MAX) begin
      sw_cand_d = sw_cand_q;
      sw_cnt_d  = sw_cnt_q;
      sw_db_d   = sw_cand_q;
    end else begin
      sw_cand_d = sw_cand_q;
      sw_cnt_d  = sw_cnt_q + DB_W'(1);
      sw_db_d   = sw_db_q;
    end

    if (btn_s2_q != btn_cand_q) begin
      btn_cand_d = btn_s2_q;
      btn_cnt_d  = {DB_W{1'b0}};
      btn_db_d   = btn_db_q;
    end else if (btn_cnt_q == DB_MAX) begin
      btn_cand_d = btn_cand_q;
      btn_cnt_d  = btn_cnt_q;
      btn_db_d   = btn_cand_q;
    end else begin
      btn_cand_d = btn_cand_q;
      btn_cnt_d  = btn_cnt_q + DB_W'(1);
      btn_db_d   = btn_db_q;
    end
  end

  // Sticky flags and press counter; a set on the same edge as a read-clear wins
  always_comb begin
    btn_rise_s   = btn_db_d & ~btn_db_q;
    sw_change_s  = (sw_db_d != sw_db_q);
    rd_confirm_s = switchCtrl && (address == ADDR_CONFIRM);
    rd_count_s   = switchCtrl && (address == ADDR_COUNT);
    rd_changed_s = switchCtrl && (address == ADDR_CHANGED);

    if (btn_rise_s) begin
      pending_d = 1'b1;
    end else if (rd_confirm_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    if (btn_rise_s) begin
      if (rd_count_s) begin
        count_d = CNT_WIDTH'(1);
      end else if (count_q == CNT_MAX) begin
        count_d = count_q;
      end else begin
        count_d = count_q + CNT_WIDTH'(1);
      end
    end else if (rd_count_s) begin
      count_d = {CNT_WIDTH{1'b0}};
    end else begin
      count_d = count_q;
    end

    if (sw_change_s) begin
      changed_d = 1'b1;
    end else if (rd_changed_s) begin
      changed_d = 1'b0;
    end else begin
      changed_d = changed_q;
    end
  end

  // Read mux over the pre-edge state
  always_comb begin
    ub_s      = sw_db_q[SW_WIDTH-1 -: 8];
    rd_data_s = {DATA_WIDTH{1'b0}};
    case (address)
      ADDR_CONFIRM: begin
        rd_data_s[0]             = pending_q;
        rd_data_s[8 +: CNT_WIDTH] = count_q;
      end
      ADDR_COUNT:   rd_data_s[CNT_WIDTH-1:0] = count_q;
      ADDR_SW:      rd_data_s[SW_WIDTH-1:0]  = sw_db_q;
      ADDR_UB_SEXT: rd_data_s = {{(DATA_WIDTH-8){ub_s[7]}}, ub_s};
      ADDR_UB_ZEXT: rd_data_s[7:0] = ub_s;
      ADDR_SW3:     rd_data_s[2:0] = sw_db_q[2:0];
      ADDR_SW8:     rd_data_s[7:0] = sw_db_q[7:0];
      ADDR_CHANGED: rd_data_s[0]   = changed_q;
      default:      rd_data_s = {DATA_WIDTH{1'b0}};
    endcase

    if (switchCtrl) begin
      data_d = rd_data_s;
    end else begin
      data_d = data_q;
    end
    valid_d = switchCtrl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q    <= {SW_WIDTH{1'b0}};
      sw_s2_q    <= {SW_WIDTH{1'b0}};
      sw_cand_q  <= {SW_WIDTH{1'b0}};
      sw_db_q    <= {SW_WIDTH{1'b0}};
      sw_cnt_q   <= {DB_W{1'b0}};
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_cand_q <= 1'b0;
      btn_db_q   <= 1'b0;
      btn_cnt_q  <= {DB_W{1'b0}};
      pending_q  <= 1'b0;
      changed_q  <= 1'b0;
      count_q    <= {CNT_WIDTH{1'b0}};
      data_q     <= {DATA_WIDTH{1'b0}};
      valid_q    <= 1'b0;
    end else begin
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      sw_cand_q  <= sw_cand_d;
      sw_db_q    <= sw_db_d;
      sw_cnt_q   <= sw_cnt_d;
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      btn_cand_q <= btn_cand_d;
      btn_db_q   <= btn_db_d;
      btn_cnt_q  <= btn_cnt_d;
      pending_q  <= pending_d;
      changed_q  <= changed_d;
      count_q    <= count_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  assign dataIOInput    = data_q;
  assign dataValid      = valid_q;
  assign confirmPending = pending_q;

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Directed bench for switch_input_ctrl with DEBOUNCE_CYCLES=4.
module tb_switch_input_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        switchCtrl;
  logic [31:0] address;
  logic [15:0] switchInput;
  logic        confirmation;
  logic [15:0] dataIOInput;
  logic        dataValid;
  logic        confirmPending;

  int checks = 0;
  int errors = 0;

  switch_input_ctrl #(
    .SW_WIDTH(16), .DATA_WIDTH(16), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .switchCtrl(switchCtrl), .address(address),
    .switchInput(switchInput), .confirmation(confirmation),
    .dataIOInput(dataIOInput), .dataValid(dataValid), .confirmPending(confirmPending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd(input logic [31:0] a);
    switchCtrl = 1'b1;
    address    = a;
    tick();
    switchCtrl = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press(input int hold, input int gap);
    confirmation = 1'b1;
    ticks(hold);
    confirmation = 1'b0;
    ticks(gap);
  endtask

  initial begin
    rst = 1'b1; switchCtrl = 1'b0; address = 32'h0;
    switchInput = 16'hFFFF; confirmation = 1'b1;
    ticks(2);
    chk("rst_data", dataIOInput, 16'h0000);
    chk("rst_valid", {15'd0, dataValid}, 16'h0000);
    chk("rst_pend", {15'd0, confirmPending}, 16'h0000);

    // inputs settle at edge 7 after release; read at edge 8
    rst = 1'b0;
    ticks(7);
    rd(32'hFFFF_FFF1);
    chk("first_read", dataIOInput, 16'hFFFF);
    chk("first_valid", {15'd0, dataValid}, 16'h0001);
    tick();
    chk("valid_drop", {15'd0, dataValid}, 16'h0000);
    chk("data_hold", dataIOInput, 16'hFFFF);
    chk("pend_after_rst", {15'd0, confirmPending}, 16'h0001);
    rd(32'hFFFF_FF00);
    chk("conf_rd0", dataIOInput, 16'h0101);
    chk("pend_clr0", {15'd0, confirmPending}, 16'h0000);
    rd(32'hFFFF_FF02);
    chk("cnt_rd0", dataIOInput, 16'h0001);
    rd(32'hFFFF_FFFB);
    chk("chg_rd0", dataIOInput, 16'h0001);

    confirmation = 1'b0; switchInput = 16'h0000;
    ticks(10);
    rd(32'hFFFF_FFFB);
    chk("chg_rd1", dataIOInput, 16'h0001);

    // debounce timing: new value visible only after edge 7
    switchInput = 16'h80A5;
    ticks(6);
    rd(32'hFFFF_FFF1);
    chk("db_edge7", dataIOInput, 16'h0000);
    rd(32'hFFFF_FFF1);
    chk("db_edge8", dataIOInput, 16'h80A5);
    rd(32'hFFFF_FFF3);
    chk("ub_sext", dataIOInput, 16'hFF80);
    rd(32'hFFFF_FFF5);
    chk("ub_zext", dataIOInput, 16'h0080);
    rd(32'hFFFF_FFF7);
    chk("sw3", dataIOInput, 16'h0005);
    rd(32'hFFFF_FFF9);
    chk("sw8", dataIOInput, 16'h00A5);

    switchInput = 16'h0000;
    ticks(10);
    rd(32'hFFFF_FFFB);
    chk("chg_rd2", dataIOInput, 16'h0001);
    switchInput = 16'h0001;
    ticks(3);
    switchInput = 16'h0000;
    ticks(10);
    rd(32'hFFFF_FFF1);
    chk("glitch_sw", dataIOInput, 16'h0000);
    rd(32'hFFFF_FFFB);
    chk("glitch_chg", dataIOInput, 16'h0000);

    for (int i = 0; i < 3; i++) press(10, 10);
    chk("pend_set", {15'd0, confirmPending}, 16'h0001);
    rd(32'hFFFF_FF00);
    chk("conf_rd1", dataIOInput, 16'h0301);
    chk("pend_clr1", {15'd0, confirmPending}, 16'h0000);
    rd(32'hFFFF_FF00);
    chk("conf_rd2", dataIOInput, 16'h0300);
    rd(32'hFFFF_FF02);
    chk("cnt_rd1", dataIOInput, 16'h0003);
    rd(32'hFFFF_FF02);
    chk("cnt_rd2", dataIOInput, 16'h0000);

    for (int i = 0; i < 260; i++) press(10, 10);
    rd(32'hFFFF_FF00);
    chk("sat_rd", dataIOInput, 16'hFF01);
    // btn_db rises on the same edge as the pending read
    confirmation = 1'b1;
    ticks(6);
    rd(32'hFFFF_FF00);
    chk("coll_rd", dataIOInput, 16'hFF00);
    chk("coll_pend", {15'd0, confirmPending}, 16'h0001);
    confirmation = 1'b0;
    ticks(10);
    rd(32'hFFFF_FF02);
    chk("sat_cnt", dataIOInput, 16'h00FF);
    confirmation = 1'b1;
    ticks(6);
    rd(32'hFFFF_FF02);
    chk("cnt_coll_rd", dataIOInput, 16'h0000);
    confirmation = 1'b0;
    ticks(10);
    rd(32'hFFFF_FF02);
    chk("cnt_coll_after", dataIOInput, 16'h0001);

    rd(32'hFFFF_FF10);
    chk("unmapped", dataIOInput, 16'h0000);
    chk("unmapped_valid", {15'd0, dataValid}, 16'h0001);

    switchInput = 16'h1234;
    ticks(2);
    rst = 1'b1;
    ticks(2);
    chk("mid_rst_data", dataIOInput, 16'h0000);
    chk("mid_rst_valid", {15'd0, dataValid}, 16'h0000);
    chk("mid_rst_pend", {15'd0, confirmPending}, 16'h0000);
    rst = 1'b0;
    ticks(6);
    rd(32'hFFFF_FFF1);
    chk("mid_rst_e7", dataIOInput, 16'h0000);
    rd(32'hFFFF_FFF1);
    chk("mid_rst_e8", dataIOInput, 16'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_input_ctrl.md
Name: switch_input_ctrl

Overview:
- Parametrised successor to the memory-mapped switch/button input port on the CPU IO bus.
- Adds three things to the plain per-address read mux:
  - two-flop synchronisation and debouncing of the switch bank and the confirm button;
  - a sticky "confirm pending" flag and a saturating press counter, both cleared on read;
  - a sticky "switch changed" flag, cleared on read.
- Sits between the board pins and the MemOrIO read path. Returns address-selected, width-extended data one cycle after a read strobe.

Parameters:
- SW_WIDTH, 16: number of switch inputs; legal range 8..DATA_WIDTH.
- DATA_WIDTH, 16: width of the read-data bus; must be >= 16.
- DEBOUNCE_CYCLES, 20000: consecutive stable cycles required before a debounced value updates; must be >= 1.
- CNT_WIDTH, 8: width of the confirm press counter; legal range 1..DATA_WIDTH-8.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- switchCtrl  in  1  read strobe; a read is performed at each rising edge where this is high.
- address  in  32  IO address of the read.
- switchInput  in  SW_WIDTH  raw asynchronous switch pins.
- confirmation  in  1  raw asynchronous confirm button.
- dataIOInput  out  DATA_WIDTH  registered read data.
- dataValid  out  1  high for exactly the one cycle after a read edge.
- confirmPending  out  1  live view of the sticky confirm flag (for an LED or interrupt).

Behaviour:
- Reset: while rst is high at an edge, all of the following clear to 0:
  - synchronisers, candidate registers, debounce counters, debounced switch value sw_db, debounced button btn_db;
  - pending flag, changed flag, press count;
  - dataIOInput, dataValid.
- Reset mid-debounce discards all partial counts. Reset on the same edge as a read wins: no data, dataValid=0.
- Sync: each raw input passes through 2 flops (s1, s2).
- Debounce, independent per channel (switch vector as one unit; button separately):
  - if s2 != cand: cand<=s2, cnt<=0;
  - else if cnt == DEBOUNCE_CYCLES-1: db<=cand, cnt holds;
  - else cnt<=cnt+1.
- Debounce timing:
  - A pin change held steady updates db at exactly the (DEBOUNCE_CYCLES+3)-th rising edge after the change.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches db.
  - Any toggle restarts the count.
- Confirm edge: a rising edge of btn_db (0->1) sets pending=1 and increments count, saturating at 2^CNT_WIDTH-1. A falling edge has no effect.
- Switch change: any edge where sw_db updates to a value different from its previous value sets changed=1.
- Read map; all unused upper bits are 0 unless stated. UB = sw_db[SW_WIDTH-1:SW_WIDTH-8]:
  - 0xFFFF_FF00: bit0=pending, bits[8+CNT_WIDTH-1:8]=count. The read clears pending.
  - 0xFFFF_FF02: bits[CNT_WIDTH-1:0]=count. The read clears count.
  - 0xFFFF_FFF1: sw_db zero-extended.
  - 0xFFFF_FFF3: UB sign-extended to DATA_WIDTH.
  - 0xFFFF_FFF5: UB zero-extended.
  - 0xFFFF_FFF7: sw_db[2:0] zero-extended.
  - 0xFFFF_FFF9: sw_db[7:0] zero-extended.
  - 0xFFFF_FFFB: bit0=changed. The read clears changed.
  - Any other address: 0, dataValid still 1.
- Read timing:
  - Read edge: dataIOInput <= mux of the pre-edge state; dataValid<=1.
  - Non-read edge: dataIOInput holds its value; dataValid<=0.
- Simultaneous events:
  - Set and read-clear on the same edge: set wins, so the flag stays 1. The read returns the pre-edge value.
  - Count increment and count-clear read on the same edge: count becomes 1. The read returns the old count.
- confirmPending = pending register (no extra latency).

Test Plan (DEBOUNCE_CYCLES=4, SW_WIDTH=16, DATA_WIDTH=16, CNT_WIDTH=8):
- Reset: hold rst 2 cycles with switchInput=0xFFFF and confirmation=1 -> all outputs 0. Release, hold inputs steady, read 0xFFFF_FFF1 at edge 8 after release -> dataIOInput=0xFFFF, dataValid=1 for exactly 1 cycle.
- Debounce timing: switchInput 0x0000->0x80A5 -> sw_db updates at edge 7, not edge 6. Then:
  - read 0xFFFF_FFF3 -> 0xFF80;
  - read 0xFFFF_FFF5 -> 0x0080;
  - read 0xFFFF_FFF7 -> 0x0005;
  - read 0xFFFF_FFF9 -> 0x00A5.
- Glitch rejection: 3-cycle pulse 0x0000->0x0001->0x0000 -> sw_db stays 0, and a read of 0xFFFF_FFFB returns 0.
- Confirm: three clean presses, each held 10 cycles with 10-cycle gaps -> confirmPending=1; read 0xFFFF_FF00 -> 0x0301 and pending clears. Second read -> 0x0300. Read 0xFFFF_FF02 -> 0x0003, then re-read -> 0x0000.
- Saturation and collision: 260 presses -> count=0xFF. A press whose btn_db rising edge coincides with a 0xFFFF_FF00 read -> read returns bit0=old value; pending=1 afterwards.
- Unmapped and mid-op reset: read 0xFFFF_FF10 -> 0x0000 with dataValid=1. Assert rst 2 cycles into a debounce -> sw_db stays 0, and the change needs a full 7 edges after release.
